axm_mul_pipe: RTL
=================

AXM_MUL_PIPE -- requirements
Module: axm_mul_pipe

Interface
REQ-001 SHALL have parameter W, default 8: operand width, legal 4..16.
REQ-002 SHALL have parameter L, default 4: number of low x bits approximated, legal 0..W.
REQ-003 SHALL have parameter KEEP_COL, default W-1: lowest kept partial-product column in approximate mode.
REQ-004 SHALL have parameter ERR_W, default 32: statistics counter width.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge; one clock, reset asynchronous active-low.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have ports in_valid/in_ready, input/output, 1/1: operand handshake.
REQ-008 SHALL have ports x and y, input, W each: unsigned operands.
REQ-009 SHALL have port in_mode, input, 1: 0 = exact, 1 = approximate; captured with the operands.
REQ-010 SHALL have ports out_valid/out_ready, output/input, 1/1: result handshake.
REQ-011 SHALL have port z, output, 2W: product.
REQ-012 SHALL have port z_mode, output, 1: mode of the transaction presented on z.

Function
REQ-013 SHALL treat an input transfer as in_valid & in_ready on a rising edge, and an output transfer as out_valid & out_ready on a rising edge.
REQ-014 SHALL use exact mode: z = x*y, full 2W bits.
REQ-015 SHALL use approximate mode: z = ((x[W-1:L]*y) << L) + sum over i<L of ((y & {W{x[i]}}) << i), with each bit in a column below KEEP_COL cleared before summing; 2W-bit result, no overflow possible.
REQ-016 SHALL make approximate mode equal exact mode when L=0.
REQ-017 SHALL have a two-stage pipeline: S1 registers the high product and the masked low sum; S2 registers the final sum. Latency = 2 cycles from input transfer to out_valid with no stall.
REQ-018 SHALL sustain throughput of one transfer per cycle while out_ready=1.
REQ-019 SHALL drive in_ready = !S1_valid | S1 advances, where S1 advances when !S2_valid | out_ready. Combinational, with no dependence on in_valid.
REQ-020 SHALL hold z and z_mode stable while out_valid=1 and out_ready=0; no transaction is dropped or duplicated.
REQ-021 SHALL return results in input order.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear S1/S2 valid flags, giving out_valid=0, z=0, z_mode=0; in_ready=1 one cycle after rst_n deasserts.
REQ-023 SHALL discard in-flight transactions on reset mid-operation; nothing is emitted after release until a new input transfer.

Configuration
REQ-024 SHALL, with macro AXM_MUL_PIPE_ERR_STAT_EN defined, add input stat_clr (1) and outputs op_cnt (ERR_W) and err_acc (ERR_W).
REQ-025 SHALL, under that macro, on each output transfer with z_mode=1, increment op_cnt by 1 and add (x*y - z) to err_acc; both saturate at all-ones.
REQ-026 SHALL, under that macro, let stat_clr synchronously zero both counters, taking priority over a simultaneous update; rst_n clears both.
REQ-027 SHALL, without the macro, omit the ports and counter logic, leaving the pipeline unchanged.

Structure
REQ-028 SHALL place in shared package axm_pkg: mode enum (AXM_EXACT=0, AXM_APPROX=1) and a function computing the column mask from W and KEEP_COL.
REQ-029 SHALL place the low-part masked partial-product generation and sum in one combinational sub-module, axm_pp_trunc; its exact x*y copy is carried to S2 only under the macro.

Verification
REQ-030 SHALL cover: W=8, L=4, KEEP_COL=7, approx, x=255, y=255 -> z=64528 two cycles later, z_mode=1.
REQ-031 SHALL cover: approx x=15, y=15 -> z=0; exact x=15, y=15 -> z=225; exact x=200, y=123 -> z=24600.
REQ-032 SHALL cover: back-to-back 3 transfers, then out_ready=0 for 3 cycles -> in_ready=0 once S1 and S2 are full, z held stable, then all 3 results emitted in order.
REQ-033 SHALL cover: rst_n pulsed low with 2 transactions in flight -> out_valid=0 immediately, no stale outputs after release.
REQ-034 SHALL cover: with AXM_MUL_PIPE_ERR_STAT_EN, approx 255x255 then exact 3x3 -> op_cnt=1, err_acc=497; stat_clr -> both 0.
REQ-035 SHALL cover: random sweep for L in {0,4,8} against a reference model; L=0 approx always equals x*y.

Source files
------------

// File: rtl/axm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axm_pkg
//  Brief    : Shared types and helpers for the approximate multiplier pipeline:
//             the transaction mode enum and the kept-column mask builder.
//  Revision : 1.0 - initial release
// ============================================================================
package axm_pkg;

  typedef enum logic {
    AXM_EXACT  = 1'b0,
    AXM_APPROX = 1'b1
  } axm_mode_e;

  // Widest product supported (W <= 16).
  localparam int AXM_MAX_PW = 32;

  // Bit c set when product column c survives truncation (c >= keep_col).
  function automatic logic [AXM_MAX_PW-1:0] axm_col_mask(input int w, input int keep_col);
    logic [AXM_MAX_PW-1:0] m;
    m = '0;
    for (int c = 0; c < AXM_MAX_PW; c++) begin
      if ((c < 2 * w) && (c >= keep_col)) m[c] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axm_pp_trunc.sv
`default_nettype none
// ============================================================================
//  Module   : axm_pp_trunc
//  Brief    : Combinational partial-product generator. Produces the shifted
//             high product (x[W-1:L]*y << L) and the sum of the L low
//             partial-product rows, with columns below KEEP_COL dropped when
//             approx=1. Optional macro AXM_MUL_PIPE_ERR_STAT_EN adds the exact
//             x*y output used by the error statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module axm_pp_trunc
  import axm_pkg::*;
#(
  parameter int W        = 8,
  parameter int L        = 4,
  parameter int KEEP_COL = W - 1
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           approx,
  output logic [2*W-1:0] hi_prod,
  output logic [2*W-1:0] lo_sum
`ifdef AXM_MUL_PIPE_ERR_STAT_EN
  ,
  output logic [2*W-1:0] exact_prod
`endif
);

  localparam logic [AXM_MAX_PW-1:0] FULL_MASK = axm_col_mask(W, KEEP_COL);
  localparam logic [2*W-1:0]        COL_MASK  = FULL_MASK[2*W-1:0];

  logic [2*W-1:0] row_mask;
  logic [2*W-1:0] row;

  // Upper x bits are multiplied exactly; shifting x right by L and back keeps
  // the L = W case legal without a zero-width slice.
  assign hi_prod = ({{W{1'b0}}, (x >> L)} * {{W{1'b0}}, y}) << L;

`ifdef AXM_MUL_PIPE_ERR_STAT_EN
  assign exact_prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
`endif

  // Sum the low rows; in exact mode the mask is all-ones so hi+lo == x*y.
  always_comb begin
    row_mask = approx ? COL_MASK : {(2*W){1'b1}};
    row      = '0;
    lo_sum   = '0;
    for (int i = 0; i < L; i++) begin
      row    = {{W{1'b0}}, (y & {W{x[i]}})} << i;
      lo_sum = lo_sum + (row & row_mask);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axm_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : axm_mul_pipe
//  Brief    : Two-stage valid/ready multiplier with exact and approximate
//             (low-column truncated) modes. S1 holds high product and low sum,
//             S2 holds the final product. Optional macro
//             AXM_MUL_PIPE_ERR_STAT_EN adds saturating op/error counters.
//  Revision : 1.0 - initial release
// ============================================================================
module axm_mul_pipe
  import axm_pkg::*;
#(
  parameter int W        = 8,
  parameter int L        = 4,
  parameter int KEEP_COL = W - 1,
  parameter int ERR_W    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] z,
  output logic           z_mode
`ifdef AXM_MUL_PIPE_ERR_STAT_EN
  ,
  input  logic             stat_clr,
  output logic [ERR_W-1:0] op_cnt,
  output logic [ERR_W-1:0] err_acc
`endif
);

  logic           s1_valid_q, s1_valid_d;
  logic [2*W-1:0] s1_hi_q, s1_hi_d;
  logic [2*W-1:0] s1_lo_q, s1_lo_d;
  axm_mode_e      s1_mode_q, s1_mode_d;
  logic           s2_valid_q, s2_valid_d;
  logic [2*W-1:0] s2_z_q, s2_z_d;
  axm_mode_e      s2_mode_q, s2_mode_d;

  logic           s1_adv;
  logic           in_fire;
  logic [2*W-1:0] pp_hi;
  logic [2*W-1:0] pp_lo;

  // S1 may move into S2 whenever S2 is empty or being drained this cycle.
  assign s1_adv    = !s2_valid_q | out_ready;
  assign in_ready  = !s1_valid_q | s1_adv;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = s2_valid_q;
  assign z         = s2_z_q;
  assign z_mode    = s2_mode_q;

`ifdef AXM_MUL_PIPE_ERR_STAT_EN
  logic [2*W-1:0] pp_exact;
  logic [2*W-1:0] s1_exact_q, s1_exact_d;
  logic [2*W-1:0] s2_exact_q, s2_exact_d;
`endif

  axm_pp_trunc #(
    .W        (W),
    .L        (L),
    .KEEP_COL (KEEP_COL)
  ) u_pp (
    .x          (x),
    .y          (y),
    .approx     (in_mode),
    .hi_prod    (pp_hi),
    .lo_sum     (pp_lo)
`ifdef AXM_MUL_PIPE_ERR_STAT_EN
    ,
    .exact_prod (pp_exact)
`endif
  );

  // Next-state for both pipeline stages; data only moves on a transfer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_hi_d    = s1_hi_q;
    s1_lo_d    = s1_lo_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_z_d     = s2_z_q;
    s2_mode_d  = s2_mode_q;
`ifdef AXM_MUL_PIPE_ERR_STAT_EN
    s1_exact_d = s1_exact_q;
    s2_exact_d = s2_exact_q;
`endif
    if (in_ready) s1_valid_d = in_valid;
    if (in_fire) begin
      s1_hi_d   = pp_hi;
      s1_lo_d   = pp_lo;
      s1_mode_d = axm_mode_e'(in_mode);
`ifdef AXM_MUL_PIPE_ERR_STAT_EN
      s1_exact_d = pp_exact;
`endif
    end
    if (s1_adv) s2_valid_d = s1_valid_q;
    if (s1_adv && s1_valid_q) begin
      s2_z_d    = s1_hi_q + s1_lo_q;
      s2_mode_d = s1_mode_q;
`ifdef AXM_MUL_PIPE_ERR_STAT_EN
      s2_exact_d = s1_exact_q;
`endif
    end
  end

  // Pipeline registers; reset empties both stages and zeroes the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_hi_q    <= '0;
      s1_lo_q    <= '0;
      s1_mode_q  <= AXM_EXACT;
      s2_valid_q <= 1'b0;
      s2_z_q     <= '0;
      s2_mode_q  <= AXM_EXACT;
`ifdef AXM_MUL_PIPE_ERR_STAT_EN
      s1_exact_q <= '0;
      s2_exact_q <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_hi_q    <= s1_hi_d;
      s1_lo_q    <= s1_lo_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_z_q     <= s2_z_d;
      s2_mode_q  <= s2_mode_d;
`ifdef AXM_MUL_PIPE_ERR_STAT_EN
      s1_exact_q <= s1_exact_d;
      s2_exact_q <= s2_exact_d;
`endif
    end
  end

`ifdef AXM_MUL_PIPE_ERR_STAT_EN
  // Accumulator is wide enough to catch a carry out of either operand.
  localparam int SW = ((ERR_W > 2 * W) ? ERR_W : 2 * W) + 1;
  localparam logic [ERR_W-1:0] CNT_ONE = ERR_W'(1);

  logic [ERR_W-1:0] op_cnt_q, op_cnt_d;
  logic [ERR_W-1:0] err_acc_q, err_acc_d;
  logic [2*W-1:0]   err_diff;
  logic [SW-1:0]    acc_sum;
  logic             out_fire;

  assign out_fire = s2_valid_q & out_ready;
  assign err_diff = s2_exact_q - s2_z_q;
  assign op_cnt   = op_cnt_q;
  assign err_acc  = err_acc_q;

  // Saturating statistics over approximate transfers; clear wins over update.
  always_comb begin
    op_cnt_d  = op_cnt_q;
    err_acc_d = err_acc_q;
    acc_sum   = {{(SW - ERR_W){1'b0}}, err_acc_q} + {{(SW - 2 * W){1'b0}}, err_diff};
    if (stat_clr) begin
      op_cnt_d  = '0;
      err_acc_d = '0;
    end else if (out_fire && (s2_mode_q == AXM_APPROX)) begin
      if (op_cnt_q != {ERR_W{1'b1}}) op_cnt_d = op_cnt_q + CNT_ONE;
      err_acc_d = (|acc_sum[SW-1:ERR_W]) ? {ERR_W{1'b1}} : acc_sum[ERR_W-1:0];
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q  <= '0;
      err_acc_q <= '0;
    end else begin
      op_cnt_q  <= op_cnt_d;
      err_acc_q <= err_acc_d;
    end
  end
`endif

endmodule
`default_nettype wire
